// File: rtl/microcode_sequencer.sv
// Microcode sequencer: step counter, ALU flag register, halt state and control-word decode.
// Define SEQ_SINGLE_STEP_EN to add i_step_mode/i_step_go single-step gating.
module microcode_sequencer #(
  parameter int INSTRUCTION_WIDTH = 4,
  parameter int INSTRUCTION_STEPS = 8,
  parameter bit MASK_ADV          = 1'b0,
  localparam int STEP_WIDTH         = $clog2(INSTRUCTION_STEPS),
  localparam int CONTROL_WORD_WIDTH = 17
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [INSTRUCTION_WIDTH-1:0]  i_instruction,
  input  logic                          i_zero,
  input  logic                          i_carry,
  input  logic                          i_odd,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                          i_step_mode,
  input  logic                          i_step_go,
`endif
  output logic [CONTROL_WORD_WIDTH-1:0] o_control_word,
  output logic [STEP_WIDTH-1:0]         o_step,
  output logic                          o_halted,
  output logic                          o_fault
);

  typedef logic [CONTROL_WORD_WIDTH-1:0] cw_t;
  localparam cw_t ONE   = CONTROL_WORD_WIDTH'(1);
  localparam cw_t c_HLT = ONE << 16;
  localparam cw_t c_MI  = ONE << 15;
  localparam cw_t c_RI  = ONE << 14;
  localparam cw_t c_RO  = ONE << 13;
  localparam cw_t c_IO  = ONE << 12;
  localparam cw_t c_II  = ONE << 11;
  localparam cw_t c_AI  = ONE << 10;
  localparam cw_t c_AO  = ONE << 9;
  localparam cw_t c_EO  = ONE << 8;
  localparam cw_t c_SU  = ONE << 7;
  localparam cw_t c_BI  = ONE << 6;
  localparam cw_t c_OI  = ONE << 5;
  localparam cw_t c_CE  = ONE << 4;
  localparam cw_t c_CO  = ONE << 3;
  localparam cw_t c_J   = ONE << 2;
  localparam cw_t c_EL  = ONE << 1;
  localparam cw_t c_ADV = ONE;

  localparam logic [STEP_WIDTH-1:0] S0    = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] S1    = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] S2    = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] S3    = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] S4    = STEP_WIDTH'(4);
  localparam logic [STEP_WIDTH-1:0] SLAST = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t                 state_q, state_d;
  logic [STEP_WIDTH-1:0]  step_q, step_d;
  logic [2:0]             flags_q, flags_d;   // {z, c, o}
  logic                   fault_q, fault_d;

  logic       ext_nop;
  logic [3:0] op;
  logic       jump_flag;
  logic       advance;
  cw_t        raw_cw;
  cw_t        cw;

  // Opcodes wider than four bits with any upper bit set fall through to NOP.
  assign ext_nop = (i_instruction >> 4) != '0;
  assign op      = ext_nop ? 4'h0 : i_instruction[3:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign advance = !i_step_mode || i_step_go;
`else
  assign advance = 1'b1;
`endif

  always_comb begin
    jump_flag = 1'b0;
    case (op)
      4'h9:    jump_flag = flags_q[2];
      4'hA:    jump_flag = flags_q[1];
      4'hB:    jump_flag = flags_q[0];
      default: jump_flag = 1'b0;
    endcase
  end

  always_comb begin
    raw_cw = '0;
    if (step_q == S0) begin
      raw_cw = c_MI | c_CO;
    end else if (step_q == S1) begin
      raw_cw = c_RO | c_II | c_CE;
    end else begin
      case (op)
        4'h1: begin
          if (step_q == S2)      raw_cw = c_IO | c_MI;
          else if (step_q == S3) raw_cw = c_RO | c_AI | c_ADV;
        end
        4'h2, 4'h3: begin
          if (step_q == S2)      raw_cw = c_IO | c_MI;
          else if (step_q == S3) raw_cw = c_RO | c_BI;
          else if (step_q == S4) raw_cw = c_EO | c_AI | c_EL | c_ADV | ((op == 4'h3) ? c_SU : '0);
        end
        4'h4: if (step_q == S2) raw_cw = c_IO | c_AI | c_ADV;
        4'h5, 4'h6: begin
          if (step_q == S2)      raw_cw = c_IO | c_BI;
          else if (step_q == S3) raw_cw = c_EO | c_AI | c_EL | c_ADV | ((op == 4'h6) ? c_SU : '0);
        end
        4'h7: begin
          if (step_q == S2)      raw_cw = c_IO | c_MI;
          else if (step_q == S3) raw_cw = c_AO | c_RI | c_ADV;
        end
        4'h8: if (step_q == S2) raw_cw = c_IO | c_J | c_ADV;
        4'h9, 4'hA, 4'hB: if (step_q == S2) raw_cw = (jump_flag ? (c_IO | c_J) : '0) | c_ADV;
        4'hE: if (step_q == S2) raw_cw = c_AO | c_OI | c_ADV;
        4'hF: if (step_q == S2) raw_cw = c_HLT;
        default: if (step_q == S2) raw_cw = c_ADV;
      endcase
    end
  end

  // MASK_ADV suppresses instruction retirement so the overrun path can be exercised.
  assign cw = (state_q == RUN && advance) ? (MASK_ADV ? (raw_cw & ~c_ADV) : raw_cw) : '0;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    flags_d = flags_q;
    fault_d = fault_q;
    if (state_q == RUN && advance) begin
      if ((cw & c_EL) != '0) flags_d = {i_zero, i_carry, i_odd};
      if ((cw & c_HLT) != '0) begin
        state_d = HALT;
      end else if ((cw & c_ADV) != '0) begin
        step_d = S0;
      end else if (step_q == SLAST) begin
        step_d  = S0;
        fault_d = 1'b1;
      end else begin
        step_d = step_q + STEP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
      step_q  <= S0;
      flags_q <= 3'b000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      flags_q <= flags_d;
      fault_q <= fault_d;
    end
  end

  assign o_control_word = cw;
  assign o_step         = step_q;
  assign o_halted       = (state_q == HALT);
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomized bench for microcode_sequencer against a table-driven instruction model.
module tb_microcode_sequencer;

  localparam logic [16:0] HLT = 17'h10000, MI = 17'h08000, RI = 17'h04000, RO = 17'h02000;
  localparam logic [16:0] IO  = 17'h01000, II = 17'h00800, AI = 17'h00400, AO = 17'h00200;
  localparam logic [16:0] EO  = 17'h00100, SU = 17'h00080, BI = 17'h00040, OI = 17'h00020;
  localparam logic [16:0] CE  = 17'h00010, CO = 17'h00008, J  = 17'h00004, EL = 17'h00002;
  localparam logic [16:0] ADV = 17'h00001;

  logic        clk = 1'b0;
  logic        rst, ovr_rst;
  logic [3:0]  instr;
  logic        zero, carry, odd;
  logic        step_mode, step_go;
  logic [16:0] cw, ovr_cw;
  logic [2:0]  step, ovr_step;
  logic        halted, fault, ovr_halted, ovr_fault;

  int n_vec  = 0;
  int n_fail = 0;

  // model state
  int          m_step;
  logic        m_z, m_c, m_o, m_halt, m_fault;
  logic [16:0] prog [16][3];

  always #5 clk = ~clk;

  microcode_sequencer u_dut (
    .i_clk(clk), .i_reset(rst), .i_instruction(instr),
    .i_zero(zero), .i_carry(carry), .i_odd(odd),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step_mode(step_mode), .i_step_go(step_go),
`endif
    .o_control_word(cw), .o_step(step), .o_halted(halted), .o_fault(fault)
  );

  microcode_sequencer #(.MASK_ADV(1'b1)) u_ovr (
    .i_clk(clk), .i_reset(ovr_rst), .i_instruction(4'h0),
    .i_zero(1'b0), .i_carry(1'b0), .i_odd(1'b0),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step_mode(1'b0), .i_step_go(1'b0),
`endif
    .o_control_word(ovr_cw), .o_step(ovr_step), .o_halted(ovr_halted), .o_fault(ovr_fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic init_prog();
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 3; k++) prog[i][k] = '0;
    prog[0][0]  = ADV;  prog[12][0] = ADV;  prog[13][0] = ADV;
    prog[1][0]  = IO | MI;  prog[1][1] = RO | AI | ADV;
    prog[2][0]  = IO | MI;  prog[2][1] = RO | BI;  prog[2][2] = EO | AI | EL | ADV;
    prog[3][0]  = IO | MI;  prog[3][1] = RO | BI;  prog[3][2] = EO | AI | EL | ADV | SU;
    prog[4][0]  = IO | AI | ADV;
    prog[5][0]  = IO | BI;  prog[5][1] = EO | AI | EL | ADV;
    prog[6][0]  = IO | BI;  prog[6][1] = EO | AI | EL | ADV | SU;
    prog[7][0]  = IO | MI;  prog[7][1] = AO | RI | ADV;
    prog[8][0]  = IO | J | ADV;
    prog[14][0] = AO | OI | ADV;
    prog[15][0] = HLT;
  endtask

  function automatic logic [16:0] m_word();
    logic flag;
    if (m_halt) return '0;
    if (step_mode && !step_go) return '0;
    if (m_step == 0) return MI | CO;
    if (m_step == 1) return RO | II | CE;
    if (instr >= 4'h9 && instr <= 4'hB) begin
      flag = (instr == 4'h9) ? m_z : (instr == 4'hA) ? m_c : m_o;
      return (m_step == 2) ? ((flag ? (IO | J) : 17'h0) | ADV) : 17'h0;
    end
    if (m_step <= 4) return prog[instr][m_step - 2];
    return '0;
  endfunction

  task automatic model_update(input logic [16:0] w);
    if (m_halt || (step_mode && !step_go)) return;
    if ((w & HLT) != 0) begin
      m_halt = 1'b1;
    end else begin
      if ((w & EL) != 0) {m_z, m_c, m_o} = {zero, carry, odd};
      if ((w & ADV) != 0) m_step = 0;
      else if (m_step == 7) begin m_step = 0; m_fault = 1'b1; end
      else m_step++;
    end
  endtask

  // called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic step_cycle(input string tag);
    logic [16:0] w;
    #1;
    w = m_word();
    check_eq({tag, "_cw"}, 32'(cw), 32'(w));
    check_eq({tag, "_step"}, 32'(step), 32'(m_step));
    check_eq({tag, "_halted"}, 32'(halted), 32'(m_halt));
    check_eq({tag, "_fault"}, 32'(fault), 32'(m_fault));
    model_update(w);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    m_step = 0; {m_z, m_c, m_o} = 3'b000; m_halt = 1'b0; m_fault = 1'b0;
    #1;
    check_eq({tag, "_rst_cw"}, 32'(cw), 32'(MI | CO));
    check_eq({tag, "_rst_step"}, 32'(step), 0);
    check_eq({tag, "_rst_halted"}, 32'(halted), 0);
    check_eq({tag, "_rst_fault"}, 32'(fault), 0);
    #1 rst = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input logic o,
                           input bit rnd);
    int n = 0;
    instr = op; zero = z; carry = c; odd = o;
    do begin
      if (rnd) begin zero = 1'($urandom); carry = 1'($urandom); odd = 1'($urandom); end
      step_cycle($sformatf("op%h", op));
      n++;
    end while (m_step != 0 && !m_halt && n < 16);
    $display("instr op=%h cycles=%0d halted=%0b flags=%b%b%b", op, n, m_halt, m_z, m_c, m_o);
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1; ovr_rst = 1'b1; instr = 4'h0;
    zero = 1'b0; carry = 1'b0; odd = 1'b0;
    step_mode = 1'b0; step_go = 1'b0;
    init_prog();
    @(negedge clk);
    do_reset("init");

    run_instr(4'h4, 0, 0, 0, 0);   // LDI
    run_instr(4'hE, 0, 0, 0, 0);   // OUT
    run_instr(4'h2, 1, 0, 0, 0);   // ADD sets z
    run_instr(4'h9, 0, 0, 0, 0);   // JIZ taken
    run_instr(4'h2, 0, 1, 1, 0);   // ADD clears z, sets c/o
    run_instr(4'h9, 0, 0, 0, 0);   // JIZ not taken
    run_instr(4'hA, 0, 0, 0, 0);   // JIC taken
    run_instr(4'hB, 0, 0, 0, 0);   // JIO taken

    // live i_zero rising during JIZ must not cause a jump
    do_reset("jizlive");
    instr = 4'h9; zero = 1'b0;
    step_cycle("jizlive0");
    step_cycle("jizlive1");
    zero = 1'b1;
    step_cycle("jizlive2");

    // reset in the middle of ADD step 3
    instr = 4'h2;
    while (m_step != 3) step_cycle("addmid");
    do_reset("addmid");

    // HLT freezes for 20 cycles
    run_instr(4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      instr = 4'($urandom); zero = 1'($urandom);
      step_cycle("halt");
    end
    do_reset("halt");

    // randomized instruction stream
    for (int t = 0; t < 150; t++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
      if ($urandom_range(0, 14) == 0) begin
        instr = op;
        for (int k = $urandom_range(1, 4); k > 0; k--) step_cycle("rndpart");
        do_reset("rndmid");
      end else begin
        run_instr(op, 0, 0, 0, 1);
        if (m_halt) begin
          for (int k = 0; k < 3; k++) step_cycle("rndhalt");
          do_reset("rndhalt");
        end
      end
    end

`ifdef SEQ_SINGLE_STEP_EN
    do_reset("ss");
    step_mode = 1'b1; instr = 4'h1;
    for (int p = 0; p < 4; p++) begin
      step_go = 1'b0; step_cycle("ss_idle");
      step_go = 1'b1; step_cycle("ss_go");
    end
    step_go = 1'b0;
    check_eq("ss_lda_done_step", 32'(step), 0);
    step_mode = 1'b0;
`endif

    // overrun: retirement masked, opcode 0 runs 0..7 and wraps with a sticky fault
    ovr_rst = 1'b1;
    #1;
    check_eq("ovr_rst_step", 32'(ovr_step), 0);
    check_eq("ovr_rst_fault", 32'(ovr_fault), 0);
    #1 ovr_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check_eq($sformatf("ovr_step%0d", k), 32'(ovr_step), k % 8);
      check_eq($sformatf("ovr_fault%0d", k), 32'(ovr_fault), (k >= 8) ? 1 : 0);
      check_eq($sformatf("ovr_cw%0d", k), 32'(ovr_cw),
               (k % 8 == 0) ? 32'(MI | CO) : (k % 8 == 1) ? 32'(RO | II | CE) : 0);
      @(negedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
